// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared weight-bank parameters, fetch FSM encoding and read-credit helper.
package weight_fetch_ctrl_pkg;

   localparam int WEIGHT_DW    = 16;
   localparam int WEIGHT_DEPTH = 28;
   localparam int WEIGHT_AW    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // A new read may issue only if the word it returns is guaranteed a FIFO slot.
   function automatic logic can_issue(input logic [1:0] occ,
                                      input logic       in_flight,
                                      input logic       pop);
      logic [2:0] sum;
      sum = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
      return (sum < 3'd2);
   endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry output FIFO; slot 0 is always the head presented to the consumer.
module weight_skid_fifo #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          din_last,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_last,
   output logic          valid,
   output logic [1:0]    count
);

   logic [DW-1:0] data_reg [2];
   logic [DW-1:0] data_next [2];
   logic          last_reg [2];
   logic          last_next [2];
   logic [1:0]    count_reg, count_next;
   logic          pop_ok, push_ok;

   assign pop_ok  = pop && (count_reg != 2'd0);
   assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

   always_comb begin
      data_next  = data_reg;
      last_next  = last_reg;
      count_next = count_reg;
      unique case ({push_ok, pop_ok})
         2'b01: begin
            data_next[0] = data_reg[1];
            last_next[0] = last_reg[1];
            count_next   = count_reg - 2'd1;
         end
         2'b10: begin
            if (count_reg == 2'd0) begin
               data_next[0] = din;
               last_next[0] = din_last;
            end else begin
               data_next[1] = din;
               last_next[1] = din_last;
            end
            count_next = count_reg + 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; the incoming word lands behind whatever remains.
            if (count_reg == 2'd1) begin
               data_next[0] = din;
               last_next[0] = din_last;
            end else begin
               data_next[0] = data_reg[1];
               last_next[0] = last_reg[1];
               data_next[1] = din;
               last_next[1] = din_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_reg[0] <= '0;
         data_reg[1] <= '0;
         last_reg[0] <= 1'b0;
         last_reg[1] <= 1'b0;
         count_reg   <= 2'd0;
      end else begin
         data_reg  <= data_next;
         last_reg  <= last_next;
         count_reg <= count_next;
      end
   end

   assign head_data = data_reg[0];
   assign head_last = last_reg[0] && (count_reg != 2'd0);
   assign valid     = (count_reg != 2'd0);
   assign count     = count_reg;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams one weight bank (addresses 0..DEPTH-1) out through a ready/valid port,
// issuing bank reads only when the output FIFO has room for the returning word.
module weight_fetch_ctrl
   import weight_fetch_ctrl_pkg::*;
#(
   parameter int DW    = WEIGHT_DW,
   parameter int DEPTH = WEIGHT_DEPTH,
   parameter int AW    = WEIGHT_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW-1:0] BRAM_ADDR,
   output logic          BRAM_EN,
   output logic          BRAM_WE,
   input  logic [DW-1:0] BRAM_DO,
   output logic [DW-1:0] W_DATA,
   output logic          W_VALID,
   input  logic          W_READY,
   output logic          W_LAST
);

   localparam int            PW        = AW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_END   = PW'(DEPTH);

   fetch_state_t  state_reg, state_next;
   logic [PW-1:0] ptr_reg, ptr_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic          en_reg, en_next;
   logic          done_reg, done_next;

   logic          pop;
   logic          issue_ok;
   logic [1:0]    fifo_count;
   logic          fifo_valid;
   logic          fifo_last;
   logic [DW-1:0] fifo_data;

   assign pop      = fifo_valid && W_READY;
   assign issue_ok = can_issue(fifo_count, en_reg, pop);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      addr_next  = addr_reg;
      en_next    = 1'b0;
      done_next  = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (START) begin
               state_next = ST_FETCH;
               en_next    = 1'b1;
               addr_next  = '0;
               ptr_next   = PW'(1);
            end
         end
         ST_FETCH: begin
            // ptr_reg is the next address to read; it stops at DEPTH instead of wrapping.
            if (en_reg && (addr_reg == LAST_ADDR)) begin
               state_next = ST_DRAIN;
            end else if ((ptr_reg < PTR_END) && issue_ok) begin
               en_next   = 1'b1;
               addr_next = ptr_reg[AW-1:0];
               ptr_next  = ptr_reg + PW'(1);
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_last) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         addr_reg  <= '0;
         en_reg    <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         addr_reg  <= addr_next;
         en_reg    <= en_next;
         done_reg  <= done_next;
      end
   end

   // Bank data for the read issued last cycle is valid at this edge; tag the final word.
   weight_skid_fifo #(
      .DW (DW)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (en_reg),
      .din       (BRAM_DO),
      .din_last  (addr_reg == LAST_ADDR),
      .pop       (pop),
      .head_data (fifo_data),
      .head_last (fifo_last),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign BUSY      = (state_reg != ST_IDLE);
   assign DONE      = done_reg;
   assign BRAM_ADDR = addr_reg;
   assign BRAM_EN   = en_reg;
   assign BRAM_WE   = 1'b0;
   assign W_DATA    = fifo_data;
   assign W_VALID   = fifo_valid;
   assign W_LAST    = fifo_last;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a falling-edge bank model and handshake monitor.
module tb_weight_fetch_ctrl;

   localparam int DW    = 16;
   localparam int DEPTH = 28;
   localparam int AW    = 5;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          START = 1'b0;
   logic          BUSY, DONE;
   logic [AW-1:0] BRAM_ADDR;
   logic          BRAM_EN, BRAM_WE;
   logic [DW-1:0] BRAM_DO = '0;
   logic [DW-1:0] W_DATA;
   logic          W_VALID;
   logic          W_READY = 1'b0;
   logic          W_LAST;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   logic [DW-1:0] got_data [0:511];
   logic          got_last [0:511];
   int            got_cyc  [0:511];
   int            got_n     = 0;
   int            en_n      = 0;
   int            done_n    = 0;
   int            done_cyc  = 0;
   int            cyc       = 0;
   int            out_issue = 0;
   int            out_pop   = 0;
   int            max_out   = 0;
   int            bad_addr  = 0;

   weight_fetch_ctrl #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .BRAM_ADDR (BRAM_ADDR),
      .BRAM_EN   (BRAM_EN),
      .BRAM_WE   (BRAM_WE),
      .BRAM_DO   (BRAM_DO),
      .W_DATA    (W_DATA),
      .W_VALID   (W_VALID),
      .W_READY   (W_READY),
      .W_LAST    (W_LAST)
   );

   always #5 CLK = ~CLK;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0100 + 16'(i);
   end

   always @(negedge CLK) begin
      if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
   end

   // Handshakes complete at the coming rising edge; inputs change only at posedge+1.
   always @(negedge CLK) begin
      cyc <= cyc + 1;
      if (RST) begin
         out_issue <= 0;
         out_pop   <= 0;
      end else begin
         if (BRAM_EN) begin
            en_n <= en_n + 1;
            if (int'(BRAM_ADDR) >= DEPTH) bad_addr <= bad_addr + 1;
         end
         if ((out_issue + int'(BRAM_EN) - out_pop) > max_out)
            max_out <= out_issue + int'(BRAM_EN) - out_pop;
         out_issue <= out_issue + int'(BRAM_EN);
         if (W_VALID && W_READY) begin
            out_pop            <= out_pop + 1;
            got_data[got_n]    <= W_DATA;
            got_last[got_n]    <= W_LAST;
            got_cyc[got_n]     <= cyc + 1;
            got_n              <= got_n + 1;
         end
         if (DONE) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc + 1;
         end
      end
   end

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(posedge CLK);
         #1;
         if (DONE === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      START = 1'b0;
      W_READY = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
      checks++; if (BRAM_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", BRAM_EN); end
      checks++; if (BRAM_ADDR !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", BRAM_ADDR); end
      checks++; if (BRAM_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", BRAM_WE); end
      checks++; if (W_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", W_VALID); end
      checks++; if (W_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", W_LAST); end
      checks++; if (W_DATA !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", W_DATA); end
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      $display("test_reset: outputs at reset values checked");
   endtask

   task automatic test_stream();
      int b, e, d, s;
      bit ok;
      W_READY = 1'b1;
      b = got_n; e = en_n; d = done_n; s = cyc;
      pulse_start();
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL stream_busy_rise: got %b expected 1", BUSY); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stream_done_timeout: got no DONE expected DONE within 200 cycles"); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL stream_busy_fall: got %b expected 0 in DONE cycle", BUSY); end
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (got_n - b !== DEPTH) begin errors++; $display("FAIL stream_count: got %0d words expected %0d", got_n - b, DEPTH); end
      checks++; if (got_cyc[b] !== s + 3) begin errors++; $display("FAIL stream_first_latency: got cycle %0d expected %0d", got_cyc[b], s + 3); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (got_data[b+i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got_data[b+i], 16'h0100 + 16'(i)); end
         checks++;
         if (got_last[b+i] !== (i == DEPTH - 1)) begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", i, got_last[b+i], i == DEPTH - 1); end
         checks++;
         if (got_cyc[b+i] !== got_cyc[b] + i) begin errors++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, got_cyc[b+i], got_cyc[b] + i); end
      end
      checks++; if (done_n - d !== 1) begin errors++; $display("FAIL stream_done_count: got %0d expected 1", done_n - d); end
      checks++; if (done_cyc !== got_cyc[b+DEPTH-1] + 1) begin errors++; $display("FAIL stream_done_timing: got cycle %0d expected %0d", done_cyc, got_cyc[b+DEPTH-1] + 1); end
      checks++; if (en_n - e !== DEPTH) begin errors++; $display("FAIL stream_reads: got %0d expected %0d", en_n - e, DEPTH); end
      $display("test_stream: %0d words received, first at +%0d cycles", got_n - b, got_cyc[b] - s);
   endtask

   task automatic test_backpressure();
      int b, e, d, k;
      bit ok;
      logic [3:0] pat;
      pat = 4'b1001;
      b = got_n; e = en_n; d = done_n;
      START = 1'b1;
      W_READY = pat[0];
      ok = 1'b0;
      k = 0;
      while (!ok && k < 400) begin
         @(posedge CLK);
         #1;
         START = 1'b0;
         if (DONE === 1'b1) ok = 1'b1;
         k++;
         W_READY = pat[k % 4];
      end
      checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no DONE expected DONE within 400 cycles"); end
      W_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (got_n - b !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d words expected %0d", got_n - b, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (got_data[b+i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[b+i], 16'h0100 + 16'(i)); end
      end
      checks++; if (en_n - e !== DEPTH) begin errors++; $display("FAIL bp_reads: got %0d expected %0d", en_n - e, DEPTH); end
      checks++; if (max_out > 2) begin errors++; $display("FAIL bp_occupancy: got %0d expected at most 2", max_out); end
      checks++; if (done_n - d !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_n - d); end
      checks++; if (bad_addr !== 0) begin errors++; $display("FAIL bp_addr_range: got %0d out-of-range reads expected 0", bad_addr); end
      $display("test_backpressure: %0d words in %0d cycles, peak occupancy %0d", got_n - b, k, max_out);
   endtask

   task automatic test_stall();
      int b, e, d;
      bit ok;
      W_READY = 1'b0;
      b = got_n; e = en_n; d = done_n;
      START = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge CLK);
         #1;
         START = 1'b0;
         if (i >= 2) begin
            checks++; if (W_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, W_VALID); end
            checks++; if (W_DATA !== 16'h0100) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 0100", i, W_DATA); end
         end
      end
      checks++; if (en_n - e !== 2) begin errors++; $display("FAIL stall_reads: got %0d expected 2", en_n - e); end
      checks++; if (got_n !== b) begin errors++; $display("FAIL stall_no_handshake: got %0d words expected 0", got_n - b); end
      W_READY = 1'b1;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout: got no DONE expected DONE within 200 cycles"); end
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (got_n - b !== DEPTH) begin errors++; $display("FAIL stall_count: got %0d words expected %0d", got_n - b, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (got_data[b+i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL stall_data_seq[%0d]: got %h expected %h", i, got_data[b+i], 16'h0100 + 16'(i)); end
      end
      checks++; if (done_n - d !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_n - d); end
      $display("test_stall: 2 reads during stall, %0d words after release", got_n - b);
   endtask

   task automatic test_restart();
      int b, e, d, k;
      bit ok;
      W_READY = 1'b1;
      b = got_n; e = en_n; d = done_n;
      pulse_start();
      k = 0;
      while ((got_n - b) < 5 && k < 50) begin
         @(posedge CLK);
         #1;
         k++;
      end
      pulse_start();
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL restart_busy_mid: got %b expected 1", BUSY); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_done1_timeout: got no DONE expected DONE within 200 cycles"); end
      checks++; if (got_n - b !== DEPTH) begin errors++; $display("FAIL restart_count1: got %0d words expected %0d", got_n - b, DEPTH); end
      pulse_start();
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL restart_busy_second: got %b expected 1", BUSY); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_done2_timeout: got no DONE expected DONE within 200 cycles"); end
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (got_n - b !== 2 * DEPTH) begin errors++; $display("FAIL restart_count2: got %0d words expected %0d", got_n - b, 2 * DEPTH); end
      for (int i = 0; i < 2 * DEPTH; i++) begin
         checks++;
         if (got_data[b+i] !== 16'h0100 + 16'(i % DEPTH)) begin errors++; $display("FAIL restart_data[%0d]: got %h expected %h", i, got_data[b+i], 16'h0100 + 16'(i % DEPTH)); end
      end
      checks++; if (done_n - d !== 2) begin errors++; $display("FAIL restart_done_count: got %0d expected 2", done_n - d); end
      checks++; if (en_n - e !== 2 * DEPTH) begin errors++; $display("FAIL restart_reads: got %0d expected %0d", en_n - e, 2 * DEPTH); end
      $display("test_restart: two passes, %0d words, %0d DONE pulses", got_n - b, done_n - d);
   endtask

   task automatic test_reset_mid();
      int b, d, k;
      bit ok;
      W_READY = 1'b1;
      b = got_n;
      pulse_start();
      k = 0;
      while ((got_n - b) < 12 && k < 50) begin
         @(posedge CLK);
         #1;
         k++;
      end
      checks++; if (got_n - b !== 12) begin errors++; $display("FAIL midrst_reach12: got %0d words expected 12", got_n - b); end
      RST = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
      checks++; if (BRAM_EN !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b expected 0", BRAM_EN); end
      checks++; if (BRAM_ADDR !== 5'd0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", BRAM_ADDR); end
      checks++; if (W_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", W_VALID); end
      checks++; if (W_LAST !== 1'b0) begin errors++; $display("FAIL midrst_last: got %b expected 0", W_LAST); end
      checks++; if (W_DATA !== 16'h0000) begin errors++; $display("FAIL midrst_data: got %h expected 0000", W_DATA); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", DONE); end
      d = done_n;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      checks++; if (done_n !== d) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_n - d); end
      checks++; if (W_VALID !== 1'b0) begin errors++; $display("FAIL midrst_idle_valid: got %b expected 0", W_VALID); end
      b = got_n;
      d = done_n;
      pulse_start();
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_done_timeout: got no DONE expected DONE within 200 cycles"); end
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (got_n - b !== DEPTH) begin errors++; $display("FAIL midrst_count: got %0d words expected %0d", got_n - b, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (got_data[b+i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL midrst_data_seq[%0d]: got %h expected %h", i, got_data[b+i], 16'h0100 + 16'(i)); end
      end
      checks++; if (done_n - d !== 1) begin errors++; $display("FAIL midrst_done_count: got %0d expected 1", done_n - d); end
      $display("test_reset_mid: transfer abandoned, restart delivered %0d words", got_n - b);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
